// File: rtl/ahb_burst_addr_gen.sv
// ahb_burst_addr_gen: AHB-Lite burst address tracker; optional BURST_ERR_CHECK_EN adds alignment/SEQ/1KB error pulses
module ahb_burst_addr_gen #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_BYTES = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [ADDR_W-1:0]             haddr,
    input  logic                          hwrite,
    input  logic                          hready,
    input  logic [2:0]                    hburst,
    input  logic [1:0]                    htrans,
    input  logic [2:0]                    hsize,
    output logic [ADDR_W-1:0]             read_addr,
    output logic [1:0]                    trans_out,
    output logic [$clog2(LINE_BYTES)-1:0] read_addr_offset,
    output logic [4:0]                    beat_cnt,
    output logic                          burst_last,
    output logic                          busy,
    output logic                          err
);
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));
    localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NONSEQ = 2'd2, T_SEQ = 2'd3;
    typedef enum logic {S_IDLE, S_BURST} state_t;
    state_t             state, state_n;
    logic [ADDR_W-1:0]  addr_n, step, size, seq_addr;
    logic [1:0]         trans_n;
    logic [4:0]         cnt_n, beats, beats_n;
    logic [2:0]         hs, hs_n, hs_in;
    logic               wrap, wrap_n, done, last_n, unused_ok;
    assign unused_ok        = hwrite;
    assign hs_in            = hsize > MAX_SIZE ? MAX_SIZE : hsize;
    assign step             = ADDR_W'(1) << hs;
    assign size             = ADDR_W'(beats) << hs;
    assign seq_addr         = wrap ? (read_addr & ~(size - 1'b1)) | ((read_addr + step) & (size - 1'b1))
                                   : read_addr + step;
    // beats==0 marks an unbounded INCR burst, which never completes on its own
    assign done             = beats != 5'd0 && beat_cnt == beats;
    assign busy             = state == S_BURST;
    assign read_addr_offset = read_addr[$clog2(LINE_BYTES)-1:0];
`ifdef BURST_ERR_CHECK_EN
    logic err_n, cross;
    assign cross = !wrap && seq_addr[ADDR_W-1:10] != read_addr[ADDR_W-1:10];
`endif
    always_comb begin
        state_n = state;
        addr_n  = read_addr;
        trans_n = trans_out;
        cnt_n   = beat_cnt;
        beats_n = beats;
        hs_n    = hs;
        wrap_n  = wrap;
`ifdef BURST_ERR_CHECK_EN
        err_n   = 1'b0;
`endif
        if (htrans == T_NONSEQ) begin
            addr_n  = haddr;
            trans_n = T_NONSEQ;
            cnt_n   = 5'd1;
            hs_n    = hs_in;
            wrap_n  = hburst != 3'd0 && !hburst[0];
            beats_n = hburst == 3'd0 ? 5'd1 : hburst == 3'd1 ? 5'd0 : hburst < 3'd4 ? 5'd4 : hburst < 3'd6 ? 5'd8 : 5'd16;
            state_n = hburst == 3'd0 ? S_IDLE : S_BURST;
`ifdef BURST_ERR_CHECK_EN
            err_n   = |(haddr & ((ADDR_W'(1) << hs_in) - 1'b1));
`endif
        end else if (state == S_BURST && !done && htrans == T_SEQ) begin
            addr_n  = seq_addr;
            trans_n = T_SEQ;
            cnt_n   = beat_cnt + 5'(beat_cnt != 5'd16);
`ifdef BURST_ERR_CHECK_EN
            err_n   = cross;
            state_n = cross ? S_IDLE : S_BURST;
`endif
        end else if (state == S_BURST && !done && htrans == T_BUSY) begin
            trans_n = T_BUSY;
        end else begin
`ifdef BURST_ERR_CHECK_EN
            err_n   = htrans == T_SEQ && state != S_BURST;
`endif
            trans_n = T_IDLE;
            state_n = S_IDLE;
        end
        last_n = state_n == S_BURST && beats_n != 5'd0 && cnt_n == beats_n;
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_IDLE;
            read_addr  <= '0;
            trans_out  <= T_IDLE;
            beat_cnt   <= '0;
            beats      <= '0;
            hs         <= '0;
            wrap       <= 1'b0;
            burst_last <= 1'b0;
        end else if (hready) begin
            state      <= state_n;
            read_addr  <= addr_n;
            trans_out  <= trans_n;
            beat_cnt   <= cnt_n;
            beats      <= beats_n;
            hs         <= hs_n;
            wrap       <= wrap_n;
            burst_last <= last_n;
        end
    end
`ifdef BURST_ERR_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rstn) err <= 1'b0;
        else       err <= hready && err_n;
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_ahb_burst_addr_gen.sv
// tb_ahb_burst_addr_gen: directed and random checks against a closed-form burst address model
module tb_ahb_burst_addr_gen;
    logic        clk = 1'b0, rstn, hwrite, hready;
    logic [31:0] haddr, read_addr;
    logic [2:0]  hburst, hsize;
    logic [1:0]  htrans, trans_out;
    logic [3:0]  read_addr_offset;
    logic [4:0]  beat_cnt;
    logic        burst_last, busy, err;
    int          errs = 0, checks = 0;
    bit          act, wr;
    int unsigned k, n, sz;
    logic [31:0] st, e_addr;
    logic [1:0]  e_trans;
    logic [4:0]  e_cnt;
    bit          e_last, e_err;

    ahb_burst_addr_gen dut (
        .clk(clk), .rstn(rstn), .haddr(haddr), .hwrite(hwrite), .hready(hready),
        .hburst(hburst), .htrans(htrans), .hsize(hsize), .read_addr(read_addr),
        .trans_out(trans_out), .read_addr_offset(read_addr_offset), .beat_cnt(beat_cnt),
        .burst_last(burst_last), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // address of beat kk, computed directly from the burst start rather than stepwise
    function automatic logic [31:0] addr_of(input int unsigned kk);
        logic [31:0] stp, size, base;
        stp = 32'd1 << sz;
        if (!wr) return st + kk * stp;
        size = n * stp;
        base = st & ~(size - 1);
        return base + ((st - base + kk * stp) % size);
    endfunction

    task automatic model();
        logic [31:0] nx;
        bit fin;
        e_err = 1'b0;
        fin   = n != 0 && k + 1 == n;
        if (!rstn) begin
            act = 0; e_addr = 0; e_trans = 0; e_cnt = 0; e_last = 0; k = 0; n = 0;
        end else if (hready) begin
            if (htrans == 2'd2) begin
                st = haddr; sz = hsize > 3'd2 ? 2 : int'(hsize);
                n  = hburst == 0 ? 1 : hburst == 1 ? 0 : hburst < 4 ? 4 : hburst < 6 ? 8 : 16;
                wr = hburst != 0 && !hburst[0];
                k = 0; act = hburst != 0; e_addr = haddr; e_trans = 2'd2; e_cnt = 5'd1;
`ifdef BURST_ERR_CHECK_EN
                e_err = (haddr % (32'd1 << sz)) != 0;
`endif
            end else if (act && !fin && htrans == 2'd3) begin
                k++;
                nx = addr_of(k);
`ifdef BURST_ERR_CHECK_EN
                e_err = !wr && nx[31:10] != e_addr[31:10];
                if (e_err) act = 0;
`endif
                e_addr = nx; e_trans = 2'd3; e_cnt = k + 1 > 16 ? 5'd16 : 5'(k + 1);
            end else if (act && !fin && htrans == 2'd1) begin
                e_trans = 2'd1;
            end else begin
`ifdef BURST_ERR_CHECK_EN
                e_err = htrans == 2'd3 && !act;
`endif
                e_trans = 2'd0; act = 0;
            end
            e_last = act && n != 0 && k + 1 == n;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic cyc(input logic r, input logic rdy, input logic [1:0] t, input logic [2:0] b,
                       input logic [2:0] s, input logic [31:0] a);
        rstn = r; hready = rdy; htrans = t; hburst = b; hsize = s; haddr = a;
        @(posedge clk);
        model();
        #1;
        chk("read_addr", read_addr, e_addr);
        chk("trans_out", 32'(trans_out), 32'(e_trans));
        chk("offset", 32'(read_addr_offset), 32'(e_addr[3:0]));
        chk("beat_cnt", 32'(beat_cnt), 32'(e_cnt));
        chk("burst_last", 32'(burst_last), 32'(e_last));
        chk("busy", 32'(busy), 32'(act));
        chk("err", 32'(err), 32'(e_err));
    endtask

    initial begin
        hwrite = 0;
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("reset_addr", read_addr, 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        // WRAP4 at 0x1008, word beats
        cyc(1, 1, 2, 2, 2, 32'h1008);
        chk("w4_b1", read_addr, 32'h1008);
        cyc(1, 1, 3, 2, 2, 0);
        chk("w4_b2", read_addr, 32'h100C);
        cyc(1, 1, 3, 2, 2, 0);
        chk("w4_b3", read_addr, 32'h1000);
        cyc(1, 1, 3, 2, 2, 0);
        chk("w4_b4", read_addr, 32'h1004);
        chk("w4_last", 32'(burst_last), 32'h1);
        cyc(1, 1, 3, 2, 2, 0);
        chk("w4_idle", 32'(busy), 32'h0);
        // reset mid-WRAP4
        cyc(1, 1, 2, 2, 2, 32'h1008);
        cyc(1, 1, 3, 2, 2, 0);
        cyc(0, 1, 3, 2, 2, 0);
        cyc(0, 1, 3, 2, 2, 0);
        chk("rst_cnt", 32'(beat_cnt), 32'h0);
        cyc(1, 1, 3, 2, 2, 0);
        chk("rst_seq_ign", 32'(trans_out), 32'h0);
        // INCR8 halfword beats with a two-cycle stall on beat 3
        cyc(1, 1, 2, 5, 1, 32'h2000);
        cyc(1, 1, 3, 5, 1, 0);
        cyc(1, 0, 3, 5, 1, 0);
        cyc(1, 0, 3, 5, 1, 0);
        chk("i8_stall", read_addr, 32'h2002);
        repeat (6) cyc(1, 1, 3, 5, 1, 0);
        chk("i8_end", read_addr, 32'h200E);
        chk("i8_cnt", 32'(beat_cnt), 32'h8);
        cyc(1, 1, 0, 0, 0, 0);
        // WRAP16 with a BUSY beat
        cyc(1, 1, 2, 6, 2, 32'h3034);
        cyc(1, 1, 3, 6, 2, 0);
        cyc(1, 1, 3, 6, 2, 0);
        cyc(1, 1, 1, 6, 2, 0);
        chk("w16_busy", read_addr, 32'h303C);
        cyc(1, 1, 3, 6, 2, 0);
        chk("w16_wrap", read_addr, 32'h3000);
        // INCR4 cut short by a SINGLE
        cyc(1, 1, 2, 3, 2, 32'h4000);
        cyc(1, 1, 3, 3, 2, 0);
        cyc(1, 1, 2, 0, 2, 32'h5000);
        chk("term_addr", read_addr, 32'h5000);
        chk("term_trans", 32'(trans_out), 32'h2);
        cyc(1, 1, 0, 0, 0, 0);
`ifdef BURST_ERR_CHECK_EN
        cyc(1, 1, 2, 1, 2, 32'h3FC);
        cyc(1, 1, 3, 1, 2, 0);
        chk("kb_err", 32'(err), 32'h1);
        chk("kb_addr", read_addr, 32'h400);
        cyc(1, 1, 3, 1, 2, 0);
        cyc(1, 1, 2, 0, 2, 32'h1002);
        chk("unaligned_err", 32'(err), 32'h1);
        cyc(1, 1, 0, 0, 0, 0);
`endif
        // random traffic, including oversized hsize and occasional unaligned starts
        for (int i = 0; i < 600; i++) begin
            int unsigned v, s;
            logic [1:0]  t;
            logic [31:0] a;
            v = $urandom_range(0, 9);
            t = v < 6 ? 2'd3 : v == 6 ? 2'd1 : v == 7 ? 2'd0 : 2'd2;
            s = $urandom_range(0, 7);
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a = a & ~((32'd1 << (s > 2 ? 2 : s)) - 1);
            hwrite = 1'($urandom);
            cyc($urandom_range(0, 49) != 0, $urandom_range(0, 4) != 0, t, 3'($urandom), 3'(s), a);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
